// File: rtl/branch_target_predictor.sv
// branch_target_predictor
// -----------------------
// Fetch-stage branch predictor: a direct-mapped branch target buffer whose
// entries hold {valid, tag, target, 2-bit saturating counter}. IF looks the
// current PC up combinationally (zero latency); EX trains the table on the
// rising edge and raises a combinational mispredict/redirect when the
// resolved outcome disagrees with the prediction carried down the pipe.
//
// Ports:
//   Clk, Reset        clock (rising edge), asynchronous active-low reset
//   if_pc             fetch PC to look up
//   pred_taken        lookup hit with counter in a taken state
//   pred_target       predicted target (0 when pred_taken=0)
//   ex_valid          EX holds a live instruction
//   ex_is_branch      EX instruction is a conditional branch
//   ex_pc             PC of the EX instruction
//   ex_taken          resolved outcome
//   ex_target         resolved target
//   ex_pred_taken     prediction that travelled with the instruction
//   ex_pred_target    predicted target that travelled with the instruction
//   bp_flush          synchronous invalidate of every entry
//   mispredict        flush IF/ID and ID/EX, load redirect_pc
//   redirect_pc       correct next PC (0 when mispredict=0)
//
// Optional build macro BP_STATS_EN adds saturating counters
//   stat_branches     cycles with a live branch in EX
//   stat_mispredicts  cycles with mispredict=1
`timescale 1ns/1ps

module branch_target_predictor #(
  parameter int          ADDR_W   = 32,
  parameter int          ENTRIES  = 16,
  parameter int          TAG_W    = 8,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  input  logic              bp_flush,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [ADDR_W-1:0] target_d [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [1:0]        ctr_d    [ENTRIES];

  logic [IDX_W-1:0]  if_idx_s;
  logic [TAG_W-1:0]  if_tag_s;
  logic              if_hit_s;
  logic [IDX_W-1:0]  ex_idx_s;
  logic [TAG_W-1:0]  ex_tag_s;
  logic              ex_hit_s;
  logic              ex_branch_s;

  // Only the index/tag slices of the PCs feed the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, ex_pc};

  assign if_idx_s    = if_pc[IDX_W+1:2];
  assign if_tag_s    = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx_s    = ex_pc[IDX_W+1:2];
  assign ex_tag_s    = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_branch_s = ex_valid && ex_is_branch;

  // Combinational lookup for IF and EX; reads pre-update state (no bypass).
  always_comb begin
    if_hit_s    = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
    ex_hit_s    = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_tag_s);
    pred_taken  = if_hit_s && ctr_q[if_idx_s][1];
    pred_target = pred_taken ? target_q[if_idx_s] : {ADDR_W{1'b0}};
  end

  // Mispredict detection and redirect, purely a function of the EX inputs.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = {ADDR_W{1'b0}};
    if (ex_valid) begin
      if (ex_is_branch) begin
        mispredict = (ex_taken != ex_pred_taken) ||
                     (ex_taken && (ex_target != ex_pred_target));
      end else begin
        mispredict = ex_pred_taken;
      end
    end else begin
      mispredict = 1'b0;
    end
    if (mispredict) begin
      redirect_pc = (ex_is_branch && ex_taken) ? ex_target : (ex_pc + PC_STEP);
    end else begin
      redirect_pc = {ADDR_W{1'b0}};
    end
  end

  // Next-state of the table: flush beats training; an aliased non-branch
  // that would have predicted taken drops its entry.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bp_flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
        ctr_d[i]   = CTR_INIT;
      end
    end else if (ex_branch_s) begin
      if (ex_hit_s) begin
        if (ex_taken) begin
          ctr_d[ex_idx_s]    = (ctr_q[ex_idx_s] == 2'b11) ? 2'b11 : (ctr_q[ex_idx_s] + 2'b01);
          target_d[ex_idx_s] = ex_target;
        end else begin
          ctr_d[ex_idx_s]    = (ctr_q[ex_idx_s] == 2'b00) ? 2'b00 : (ctr_q[ex_idx_s] - 2'b01);
        end
      end else if (ex_taken) begin
        valid_d[ex_idx_s]  = 1'b1;
        tag_d[ex_idx_s]    = ex_tag_s;
        target_d[ex_idx_s] = ex_target;
        ctr_d[ex_idx_s]    = 2'b10;
      end else begin
        valid_d[ex_idx_s]  = valid_q[ex_idx_s];
      end
    end else if (ex_valid && !ex_is_branch && ex_hit_s && ctr_q[ex_idx_s][1]) begin
      valid_d[ex_idx_s] = 1'b0;
    end else begin
      valid_d[ex_idx_s] = valid_q[ex_idx_s];
    end
  end

  // Table state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= {TAG_W{1'b0}};
        target_q[i] <= {ADDR_W{1'b0}};
        ctr_q[i]    <= CTR_INIT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_branches_d;
  logic [31:0] stat_mispredicts_q;
  logic [31:0] stat_mispredicts_d;

  // Saturating event counters, cleared by flush.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (bp_flush) begin
      stat_branches_d    = 32'd0;
      stat_mispredicts_d = 32'd0;
    end else begin
      if (ex_branch_s && (stat_branches_q != 32'hFFFF_FFFF)) begin
        stat_branches_d = stat_branches_q + 32'd1;
      end else begin
        stat_branches_d = stat_branches_q;
      end
      if (mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
        stat_mispredicts_d = stat_mispredicts_q + 32'd1;
      end else begin
        stat_mispredicts_d = stat_mispredicts_q;
      end
    end
  end

  // Statistics register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
`timescale 1ns/1ps

module tb_branch_target_predictor;

  logic        Clk;
  logic        Reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        bp_flush;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_target_predictor dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .bp_flush       (bp_flush),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- reference model (16 entries, 8-bit tags) ----------------
  bit          m_valid  [16];
  int          m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  longint      m_br;
  longint      m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd16);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / 32'd64) % 32'd256);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit exp_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] pc);
    return exp_taken(pc) ? m_target[idx_of(pc)] : 32'd0;
  endfunction

  function automatic bit exp_mis();
    if (!ex_valid) return 1'b0;
    if (ex_is_branch)
      return (ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target));
    return ex_pred_taken;
  endfunction

  function automatic logic [31:0] exp_redirect();
    if (!exp_mis()) return 32'd0;
    return (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 32'd0; m_ctr[i] = 1;
    end
    m_br = 0; m_mis = 0;
  endtask

  task automatic model_update();
    int i;
    i = idx_of(ex_pc);
    if (!Reset) begin
      model_reset();
    end else if (bp_flush) begin
      for (int k = 0; k < 16; k++) begin m_valid[k] = 1'b0; m_ctr[k] = 1; end
      m_br = 0; m_mis = 0;
    end else begin
      if (ex_valid && ex_is_branch && m_br < 64'hFFFF_FFFF) m_br++;
      if (exp_mis() && m_mis < 64'hFFFF_FFFF) m_mis++;
      if (ex_valid && ex_is_branch) begin
        if (m_hit(ex_pc)) begin
          if (ex_taken) begin
            m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            m_target[i] = ex_target;
          end else begin
            m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (ex_taken) begin
          m_valid[i] = 1'b1; m_tag[i] = tag_of(ex_pc); m_target[i] = ex_target; m_ctr[i] = 2;
        end
      end else if (ex_valid && m_hit(ex_pc) && m_ctr[i] >= 2) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  // Apply the current inputs across one rising edge; return at the falling edge.
  task automatic step();
    model_update();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic set_ex(input bit v, input bit br, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  // ---------------------------- tests ----------------------------
  task automatic test_reset();
    Reset = 1'b0; bp_flush = 1'b0; if_pc = 32'h0040_0010;
    set_ex(1'b0, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'd0);
    model_reset();
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
      $display("FAIL reset_pred: got %b/%h want 0/00000000", pred_taken, pred_target); n_fail++;
    end
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
      $display("FAIL post_reset_pred: got %b/%h want 0/00000000", pred_taken, pred_target); n_fail++;
    end
    n_checks++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'd0) begin
      $display("FAIL exvalid0_mis: got %b/%h want 0/00000000", mispredict, redirect_pc); n_fail++;
    end
    step();
  endtask

  task automatic test_cold_taken();
    set_ex(1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'd0);
    #1;
    n_checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0040_0040) begin
      $display("FAIL cold_taken_mis: got %b/%h want 1/00400040", mispredict, redirect_pc); n_fail++;
    end
    step();
    set_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    if_pc = 32'h0040_0010;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h0040_0040) begin
      $display("FAIL cold_taken_pred: got %b/%h want 1/00400040", pred_taken, pred_target); n_fail++;
    end
  endtask

  task automatic test_saturation();
    bit exp_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    if_pc = 32'h0040_0010;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) set_ex(1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040);
      else       set_ex(1'b1, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040);
      #1;
      if (k == 4) begin
        n_checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h0040_0014) begin
          $display("FAIL sat_final_mis: got %b/%h want 1/00400014", mispredict, redirect_pc); n_fail++;
        end
      end else if (k < 3) begin
        n_checks++;
        if (mispredict !== 1'b0) begin
          $display("FAIL sat_taken_mis[%0d]: got %b want 0", k, mispredict); n_fail++;
        end
      end
      step();
      #1;
      n_checks++;
      if (pred_taken !== exp_seq[k]) begin
        $display("FAIL sat_pred[%0d]: got %b want %b", k, pred_taken, exp_seq[k]); n_fail++;
      end
    end
    set_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_alias();
    set_ex(1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'd0);
    step();
    set_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    if_pc = 32'h0040_0010;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin
      $display("FAIL alias_trained: got %b want 1", pred_taken); n_fail++;
    end
    if_pc = 32'h0040_1010;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
      $display("FAIL alias_tag_miss: got %b/%h want 0/00000000", pred_taken, pred_target); n_fail++;
    end
    // same index and tag, differs only above the tag field
    set_ex(1'b1, 1'b0, 32'h0040_4010, 1'b0, 32'd0, 1'b1, 32'h0040_0040);
    #1;
    n_checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0040_4014) begin
      $display("FAIL alias_nonbranch_mis: got %b/%h want 1/00404014", mispredict, redirect_pc); n_fail++;
    end
    step();
    set_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    if_pc = 32'h0040_0010;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      $display("FAIL alias_invalidated: got %b want 0", pred_taken); n_fail++;
    end
  endtask

  task automatic test_same_cycle_and_flush();
    set_ex(1'b1, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0100, 1'b0, 32'd0);
    step();
    if_pc = 32'h0040_0020;
    set_ex(1'b1, 1'b1, 32'h0040_0020, 1'b0, 32'd0, 1'b1, 32'h0040_0100);
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h0040_0100) begin
      $display("FAIL same_cycle_old: got %b/%h want 1/00400100", pred_taken, pred_target); n_fail++;
    end
    step();
    set_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      $display("FAIL same_cycle_new: got %b want 0", pred_taken); n_fail++;
    end
    set_ex(1'b1, 1'b1, 32'h0040_0030, 1'b1, 32'h0040_0200, 1'b0, 32'd0);
    bp_flush = 1'b1;
    step();
    bp_flush = 1'b0;
    set_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    if_pc = 32'h0040_0030;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      $display("FAIL flush_wins: got %b want 0", pred_taken); n_fail++;
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int n = 0; n < 600; n++) begin
      if_pc = 32'h0040_0000 | (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 1)) << 14);
      pc    = 32'h0040_0000 | (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 1)) << 14);
      ex_valid     = ($urandom_range(0, 7) != 0);
      ex_is_branch = ($urandom_range(0, 5) != 0);
      ex_pc        = pc;
      ex_taken     = $urandom_range(0, 1);
      ex_target    = 32'h0040_0000 | (32'($urandom_range(0, 7)) << 4);
      if ($urandom_range(0, 3) != 0) begin
        ex_pred_taken  = exp_taken(pc);
        ex_pred_target = exp_target(pc);
      end else begin
        ex_pred_taken  = $urandom_range(0, 1);
        ex_pred_target = 32'h0040_0000 | (32'($urandom_range(0, 7)) << 4);
      end
      bp_flush = ($urandom_range(0, 63) == 0);
      #1;
      n_checks++;
      if (pred_taken !== exp_taken(if_pc) || pred_target !== exp_target(if_pc)) begin
        $display("FAIL rand_pred[%0d]: pc %h got %b/%h want %b/%h", n, if_pc, pred_taken,
                 pred_target, exp_taken(if_pc), exp_target(if_pc)); n_fail++;
      end
      n_checks++;
      if (mispredict !== exp_mis() || redirect_pc !== exp_redirect()) begin
        $display("FAIL rand_mis[%0d]: got %b/%h want %b/%h", n, mispredict, redirect_pc,
                 exp_mis(), exp_redirect()); n_fail++;
      end
`ifdef BP_STATS_EN
      n_checks++;
      if (stat_branches !== 32'(m_br) || stat_mispredicts !== 32'(m_mis)) begin
        $display("FAIL rand_stats[%0d]: got %0d/%0d want %0d/%0d", n, stat_branches,
                 stat_mispredicts, m_br, m_mis); n_fail++;
      end
`endif
      step();
    end
    bp_flush = 1'b0;
    set_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_reset_mid();
    set_ex(1'b1, 1'b1, 32'h0040_0050, 1'b1, 32'h0040_0300, 1'b0, 32'd0);
    step();
    if_pc = 32'h0040_0050;
    set_ex(1'b1, 1'b1, 32'h0040_0060, 1'b1, 32'h0040_0400, 1'b0, 32'd0);
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin
      $display("FAIL premid_pred: got %b want 1", pred_taken); n_fail++;
    end
    Reset = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
      $display("FAIL midreset_pred: got %b/%h want 0/00000000", pred_taken, pred_target); n_fail++;
    end
    n_checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0040_0400) begin
      $display("FAIL midreset_mis: got %b/%h want 1/00400400", mispredict, redirect_pc); n_fail++;
    end
`ifdef BP_STATS_EN
    n_checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      $display("FAIL midreset_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts); n_fail++;
    end
`endif
    step();
    Reset = 1'b1;
    set_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    if_pc = 32'h0040_0060;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      $display("FAIL inflight_discard: got %b want 0", pred_taken); n_fail++;
    end
    step();
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    bp_flush = 1'b1;
    step();
    bp_flush = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_ex(1'b1, 1'b1, 32'h0040_0100 + 32'(k * 64), 1'b0, 32'd0, (k % 3 == 0) && (k < 9), 32'd0);
      step();
    end
    set_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    n_checks++;
    if (stat_branches !== 32'd10 || stat_mispredicts !== 32'd3) begin
      $display("FAIL stats_counts: got %0d/%0d want 10/3", stat_branches, stat_mispredicts); n_fail++;
    end
    Reset = 1'b0;
    #1;
    n_checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      $display("FAIL stats_reset: got %0d/%0d want 0/0", stat_branches, stat_mispredicts); n_fail++;
    end
    step();
    Reset = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_cold_taken();
    test_saturation();
    test_alias();
    test_same_cycle_and_flush();
    test_random();
    test_reset_mid();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
